vga_writer: RTL

Scan-out engine for the VGA output side of the frame path. It generates VGA sync timing in the `vga_clk` domain and pulls one 12-bit RGB444 pixel per active cycle from the vga_clk-side read port of the dual-clock frame FIFO. The SDRAM side fills that FIFO. The block drives the DAC pins, a frame-start pulse so the SDRAM fetcher can restart at the frame base, and a sticky underflow flag.

---
 rtl/vga_writer_if.sv | 30 +++
 rtl/vga_writer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_writer_if.sv
// ---------------------------------------------------------------------------
// vga_writer_if : frame-FIFO read port and VGA pin bundle for vga_writer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vga_writer_if;
  logic [11:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic        underflow;

  modport master (
    input  fifo_q, fifo_empty,
    output fifo_rd, vga_r, vga_g, vga_b, hsync, vsync, de, frame_start, underflow
  );

  modport slave (
    output fifo_q, fifo_empty,
    input  fifo_rd, vga_r, vga_g, vga_b, hsync, vsync, de, frame_start, underflow
  );
endinterface

`default_nettype wire

// File: rtl/vga_writer.sv
// ---------------------------------------------------------------------------
// vga_writer : VGA sync generator + FIFO pixel scan-out; option VGA_WRITER_TEST_PATTERN_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_writer #(
  parameter logic [11:0] h_disp      = 12'd640,
  parameter logic [11:0] h_fporch    = 12'd16,
  parameter logic [11:0] h_sync      = 12'd96,
  parameter logic [11:0] h_bporch    = 12'd48,
  parameter logic [11:0] v_disp      = 12'd480,
  parameter logic [11:0] v_fporch    = 12'd10,
  parameter logic [11:0] v_sync      = 12'd2,
  parameter logic [11:0] v_bporch    = 12'd33,
  parameter logic        hs_polarity = 1'b0,
  parameter logic        vs_polarity = 1'b0
) (
  input  wire logic     vga_clk,
  input  wire logic     reset,
`ifdef VGA_WRITER_TEST_PATTERN_EN
  input  wire logic     test_pattern,
`endif
  vga_writer_if.master  vif
);

  localparam logic [11:0] H_ACT_BEG = h_sync + h_bporch;
  localparam logic [11:0] H_ACT_END = H_ACT_BEG + h_disp;
  localparam logic [11:0] H_TOT     = H_ACT_END + h_fporch;
  localparam logic [11:0] H_LAST    = H_TOT - 12'd1;
  localparam logic [11:0] V_ACT_BEG = v_sync + v_bporch;
  localparam logic [11:0] V_ACT_END = V_ACT_BEG + v_disp;
  localparam logic [11:0] V_TOT     = V_ACT_END + v_fporch;
  localparam logic [11:0] V_LAST    = V_TOT - 12'd1;

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        act;
  logic        tp;

  logic        s1_hs;
  logic        s1_vs;
  logic        s1_act;
  logic        s1_miss;
  logic        s1_tp;
  logic [2:0]  s1_bar;

  logic [11:0] rgb;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic        fs_out;
  logic        uf_out;

`ifdef VGA_WRITER_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = h_disp >> 3;
  logic [11:0] h_pix;
  logic [11:0] bar_full;
  assign tp       = test_pattern;
  assign h_pix    = h_cnt - H_ACT_BEG;
  assign bar_full = h_pix / BAR_W;
`else
  assign tp = 1'b0;
`endif

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign act = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
               (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);

  // Gated on reset so no read escapes while the FIFO is being flushed.
  assign vif.fifo_rd = reset & act & ~vif.fifo_empty & ~tp;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      s1_hs   <= ~hs_polarity;
      s1_vs   <= ~vs_polarity;
      s1_act  <= 1'b0;
      s1_miss <= 1'b0;
      s1_tp   <= 1'b0;
      s1_bar  <= 3'd0;
    end else begin
      s1_hs   <= (h_cnt < h_sync) ? hs_polarity : ~hs_polarity;
      s1_vs   <= (v_cnt < v_sync) ? vs_polarity : ~vs_polarity;
      s1_act  <= act;
      s1_miss <= act & vif.fifo_empty & ~tp;
      s1_tp   <= tp;
`ifdef VGA_WRITER_TEST_PATTERN_EN
      s1_bar  <= bar_full[2:0];
`else
      s1_bar  <= 3'd0;
`endif
    end
  end

  // fifo_q carries the word read one cycle earlier, lining up with stage 1.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      rgb    <= 12'h000;
      hs_out <= ~hs_polarity;
      vs_out <= ~vs_polarity;
      de_out <= 1'b0;
      fs_out <= 1'b0;
      uf_out <= 1'b0;
    end else begin
      hs_out <= s1_hs;
      vs_out <= s1_vs;
      de_out <= s1_act;
      fs_out <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
      if (s1_act && s1_tp)
        rgb <= {{4{s1_bar[2]}}, {4{s1_bar[1]}}, {4{s1_bar[0]}}};
      else if (s1_act && !s1_miss)
        rgb <= vif.fifo_q;
      else
        rgb <= 12'h000;
      if (s1_miss)
        uf_out <= 1'b1;
      else if (fs_out)
        uf_out <= 1'b0;
    end
  end

  assign vif.vga_r       = rgb[11:8];
  assign vif.vga_g       = rgb[7:4];
  assign vif.vga_b       = rgb[3:0];
  assign vif.hsync       = hs_out;
  assign vif.vsync       = vs_out;
  assign vif.de          = de_out;
  assign vif.frame_start = fs_out;
  assign vif.underflow   = uf_out;

endmodule

`default_nettype wire
